// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate/control generation, load-use stall
// and flush handling in front of the ID/EX pipeline register.
module decode_stage #(
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ir,
   input  logic [31:0] pc,
   input  logic        flush,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        fetch_ce,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_rs1_val,
   output logic [31:0] ex_rs2_val,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2,
   output logic [4:0]  ex_rd,
   output logic [6:0]  ex_opcode,
   output logic [2:0]  ex_funct3,
   output logic        ex_funct7b5,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_branch,
   output logic        ex_jump,
   output logic        ex_illegal
);
   localparam int AW = $clog2(NREGS);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } idex_t;

   logic [31:0] rf_q [NREGS];
   logic        id_valid_q, id_valid_d;
   idex_t       idex_q, idex_d;

   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2;
   logic [31:0] rs1_val, rs2_val, imm;
   logic        reg_write, mem_read, mem_write, branch, jump, illegal;
   logic        use_rs1, use_rs2, stall, bubble;

   assign opcode = ir[6:0];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];

   // Write-first bypass lets a same-cycle writeback reach the decoder.
   assign rs1_val = (rs1 == 5'd0) ? '0 :
                    (wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1[AW-1:0]];
   assign rs2_val = (rs2 == 5'd0) ? '0 :
                    (wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2[AW-1:0]];

   always_comb begin
      imm       = '0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      illegal   = 1'b0;
      use_rs1   = 1'b1;
      use_rs2   = 1'b0;
      case (opcode)
         OP_LOAD:   begin imm = {{20{ir[31]}}, ir[31:20]}; reg_write = 1'b1; mem_read = 1'b1; end
         OP_IMM:    begin imm = {{20{ir[31]}}, ir[31:20]}; reg_write = 1'b1; end
         OP_JALR:   begin imm = {{20{ir[31]}}, ir[31:20]}; reg_write = 1'b1; jump = 1'b1; end
         OP_STORE:  begin imm = {{20{ir[31]}}, ir[31:25], ir[11:7]}; mem_write = 1'b1; use_rs2 = 1'b1; end
         OP_BRANCH: begin
            imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            branch = 1'b1; use_rs2 = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin imm = {ir[31:12], 12'b0}; reg_write = 1'b1; use_rs1 = 1'b0; end
         OP_JAL:    begin
            imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            reg_write = 1'b1; jump = 1'b1; use_rs1 = 1'b0;
         end
         OP_OP:     begin reg_write = 1'b1; use_rs2 = 1'b1; end
         OP_FENCE:  ;
         default:   illegal = 1'b1;
      endcase
   end

   // Reset is folded in so fetch is never held while the pipe is being cleared.
   assign stall = !rst && id_valid_q && !flush &&
                  idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                  ((use_rs1 && rs1 == idex_q.rd) || (use_rs2 && rs2 == idex_q.rd));
   assign fetch_ce = !stall;
   assign bubble   = rst || flush || stall || !id_valid_q;

   always_comb begin
      id_valid_d = id_valid_q;
      if (rst || flush) id_valid_d = 1'b0;
      else if (fetch_ce) id_valid_d = 1'b1;
   end

   always_comb begin
      idex_d = '0;
      if (!bubble) begin
         idex_d.valid     = 1'b1;
         idex_d.pc        = pc;
         idex_d.rs1_val   = rs1_val;
         idex_d.rs2_val   = rs2_val;
         idex_d.imm       = imm;
         idex_d.rs1       = rs1;
         idex_d.rs2       = rs2;
         idex_d.rd        = ir[11:7];
         idex_d.opcode    = opcode;
         idex_d.funct3    = ir[14:12];
         idex_d.funct7b5  = ir[30];
         idex_d.reg_write = reg_write;
         idex_d.mem_read  = mem_read;
         idex_d.mem_write = mem_write;
         idex_d.branch    = branch;
         idex_d.jump      = jump;
         idex_d.illegal   = illegal;
      end
   end

   always_ff @(posedge clk) begin
      id_valid_q <= id_valid_d;
      idex_q     <= idex_d;
      if (rst) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (wb_en && wb_rd != 5'd0) begin
         rf_q[wb_rd[AW-1:0]] <= wb_data;
      end
   end

   assign ex_valid     = idex_q.valid;
   assign ex_pc        = idex_q.pc;
   assign ex_rs1_val   = idex_q.rs1_val;
   assign ex_rs2_val   = idex_q.rs2_val;
   assign ex_imm       = idex_q.imm;
   assign ex_rs1       = idex_q.rs1;
   assign ex_rs2       = idex_q.rs2;
   assign ex_rd        = idex_q.rd;
   assign ex_opcode    = idex_q.opcode;
   assign ex_funct3    = idex_q.funct3;
   assign ex_funct7b5  = idex_q.funct7b5;
   assign ex_reg_write = idex_q.reg_write;
   assign ex_mem_read  = idex_q.mem_read;
   assign ex_mem_write = idex_q.mem_write;
   assign ex_branch    = idex_q.branch;
   assign ex_jump      = idex_q.jump;
   assign ex_illegal   = idex_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random instruction streams,
// all compared against a cycle-level behavioural model of the stage.
module tb_decode_stage;
   logic        clk, rst, flush, wb_en;
   logic [31:0] ir, pc, wb_data;
   logic [4:0]  wb_rd;
   logic        fetch_ce, ex_valid, ex_funct7b5;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal;

   decode_stage #(.NREGS(32)) dut (
      .clk(clk), .rst(rst), .ir(ir), .pc(pc), .flush(flush),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .fetch_ce(fetch_ce),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        v;
      logic [31:0] pc, a, b, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7, rw, mr, mw, br, jp, ill;
   } ex_t;

   typedef struct {
      logic [31:0] imm;
      logic        rw, mr, mw, br, jp, ill, u1, u2;
   } dec_t;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] m_rf [32];
   logic        m_idv;
   ex_t         m_ex;
   logic        last_ce;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Immediates rebuilt with signed arithmetic on the whole word.
   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      int   s;
      s = $signed(w);
      d = '{default: 0};
      d.u1 = 1'b1;
      case (w[6:0])
         7'b0000011: begin d.imm = 32'(s >>> 20); d.rw = 1; d.mr = 1; end
         7'b0010011: begin d.imm = 32'(s >>> 20); d.rw = 1; end
         7'b1100111: begin d.imm = 32'(s >>> 20); d.rw = 1; d.jp = 1; end
         7'b0100011: begin
            d.imm = 32'((s >>> 25) <<< 5) | 32'(w[11:7]); d.mw = 1; d.u2 = 1;
         end
         7'b1100011: begin
            d.imm = 32'((s >>> 31) <<< 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            d.br = 1; d.u2 = 1;
         end
         7'b0110111, 7'b0010111: begin d.imm = w & 32'hFFFFF000; d.rw = 1; d.u1 = 0; end
         7'b1101111: begin
            d.imm = 32'((s >>> 31) <<< 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            d.rw = 1; d.jp = 1; d.u1 = 0;
         end
         7'b0110011: begin d.rw = 1; d.u2 = 1; end
         7'b0001111: ;
         default:    d.ill = 1;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] rd_reg(input logic [4:0] r, input logic we,
                                          input logic [4:0] wr, input logic [31:0] wd);
      if (r == 0) return 32'd0;
      if (we && wr == r) return wd;
      return m_rf[r];
   endfunction

   task automatic compare_all();
      chk("ex_valid",   32'(ex_valid),     32'(m_ex.v));
      chk("ex_pc",      ex_pc,             m_ex.pc);
      chk("ex_rs1_val", ex_rs1_val,        m_ex.a);
      chk("ex_rs2_val", ex_rs2_val,        m_ex.b);
      chk("ex_imm",     ex_imm,            m_ex.imm);
      chk("ex_rs1",     32'(ex_rs1),       32'(m_ex.rs1));
      chk("ex_rs2",     32'(ex_rs2),       32'(m_ex.rs2));
      chk("ex_rd",      32'(ex_rd),        32'(m_ex.rd));
      chk("ex_opcode",  32'(ex_opcode),    32'(m_ex.op));
      chk("ex_funct3",  32'(ex_funct3),    32'(m_ex.f3));
      chk("ex_f7b5",    32'(ex_funct7b5),  32'(m_ex.f7));
      chk("ex_rw",      32'(ex_reg_write), 32'(m_ex.rw));
      chk("ex_mr",      32'(ex_mem_read),  32'(m_ex.mr));
      chk("ex_mw",      32'(ex_mem_write), 32'(m_ex.mw));
      chk("ex_br",      32'(ex_branch),    32'(m_ex.br));
      chk("ex_jp",      32'(ex_jump),      32'(m_ex.jp));
      chk("ex_ill",     32'(ex_illegal),   32'(m_ex.ill));
   endtask

   // One clock: apply inputs after negedge, check fetch_ce, advance model, check ID/EX.
   task automatic step(input logic r, input logic f, input logic [31:0] i, input logic [31:0] p,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
      dec_t d;
      ex_t  nx;
      logic stall;
      rst = r; flush = f; ir = i; pc = p; wb_en = we; wb_rd = wr; wb_data = wd;
      #1;
      d = decode(i);
      stall = !r && m_idv && !f && m_ex.v && m_ex.mr && m_ex.rd != 0 &&
              ((d.u1 && i[19:15] == m_ex.rd) || (d.u2 && i[24:20] == m_ex.rd));
      chk("fetch_ce", 32'(fetch_ce), 32'(!stall));
      last_ce = fetch_ce;
      nx = '{default: 0};
      if (!(r || f || stall || !m_idv)) begin
         nx.v = 1; nx.pc = p; nx.imm = d.imm;
         nx.a = rd_reg(i[19:15], we, wr, wd);
         nx.b = rd_reg(i[24:20], we, wr, wd);
         nx.rs1 = i[19:15]; nx.rs2 = i[24:20]; nx.rd = i[11:7];
         nx.op = i[6:0]; nx.f3 = i[14:12]; nx.f7 = i[30];
         nx.rw = d.rw; nx.mr = d.mr; nx.mw = d.mw; nx.br = d.br; nx.jp = d.jp; nx.ill = d.ill;
      end
      if (r || f) m_idv = 0;
      else if (!stall) m_idv = 1;
      if (r) begin
         for (int k = 0; k < 32; k++) m_rf[k] = 0;
      end else if (we && wr != 0) begin
         m_rf[wr] = wd;
      end
      @(posedge clk);
      #1;
      m_ex = nx;
      compare_all();
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [11];
      logic [31:0] w;
      ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110111,
              7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111, 7'b1111111};
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom);
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   localparam logic [31:0] ADDI5 = 32'h00500093;
   localparam logic [31:0] LW    = 32'h0000A103;
   localparam logic [31:0] ADD   = 32'h002101B3;
   localparam logic [31:0] NOP   = 32'h00000013;

   initial begin
      logic [31:0] cur_ir, cur_pc;
      m_idv = 0; m_ex = '{default: 0}; last_ce = 1;
      for (int k = 0; k < 32; k++) m_rf[k] = 0;
      rst = 1; flush = 0; ir = 0; pc = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
      @(negedge clk);

      step(1, 0, NOP, 0, 0, 0, 0);
      step(1, 0, NOP, 0, 0, 0, 0);
      chk("rst_ce", 32'(fetch_ce), 32'd1);
      chk("rst_valid", 32'(ex_valid), 32'd0);

      // Basic decode: first IR after reset is dropped.
      step(0, 0, ADDI5, 0, 0, 0, 0);
      step(0, 0, ADDI5, 0, 0, 0, 0);
      chk("addi_valid", 32'(ex_valid), 32'd1);
      chk("addi_rd", 32'(ex_rd), 32'd1);
      chk("addi_imm", ex_imm, 32'd5);
      chk("addi_rs1v", ex_rs1_val, 32'd0);
      chk("addi_rw", 32'(ex_reg_write), 32'd1);
      chk("addi_pc", ex_pc, 32'd0);

      // Load-use: one stall cycle, one bubble.
      step(0, 0, LW, 4, 0, 0, 0);
      step(0, 0, ADD, 8, 0, 0, 0);
      chk("lu_ce", 32'(last_ce), 32'd0);
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      step(0, 0, ADD, 8, 0, 0, 0);
      chk("lu_ce2", 32'(last_ce), 32'd1);
      chk("lu_issue", 32'(ex_valid), 32'd1);
      chk("lu_rs1", 32'(ex_rs1), 32'd2);
      chk("lu_rs2", 32'(ex_rs2), 32'd2);

      // Bypass, then x0 writes ignored.
      step(0, 0, 32'h00018233, 12, 1, 3, 32'hDEADBEEF);
      chk("bypass", ex_rs1_val, 32'hDEADBEEF);
      step(0, 0, NOP, 16, 1, 0, 32'h1234);
      step(0, 0, 32'h00000233, 20, 0, 0, 0);
      chk("x0_rs1", ex_rs1_val, 32'd0);
      chk("x0_rs2", ex_rs2_val, 32'd0);
      step(0, 0, 32'h000182B3, 24, 0, 0, 0);
      chk("rf_x3", ex_rs1_val, 32'hDEADBEEF);

      // Immediates.
      step(0, 0, 32'hFE000EE3, 28, 0, 0, 0);
      chk("beq_imm", ex_imm, 32'hFFFFFFFC);
      chk("beq_br", 32'(ex_branch), 32'd1);
      step(0, 0, 32'h001000EF, 32, 0, 0, 0);
      chk("jal_imm", ex_imm, 32'h00000800);
      chk("jal_jp", 32'(ex_jump), 32'd1);
      step(0, 0, 32'h123450B7, 36, 0, 0, 0);
      chk("lui_imm", ex_imm, 32'h12345000);

      // Flush: two bubbles, then the target.
      step(0, 1, ADDI5, 40, 0, 0, 0);
      chk("fl_b1", 32'(ex_valid), 32'd0);
      step(0, 0, 32'h00700093, 44, 0, 0, 0);
      chk("fl_b2", 32'(ex_valid), 32'd0);
      step(0, 0, 32'h00900093, 100, 0, 0, 0);
      chk("fl_tgt", 32'(ex_valid), 32'd1);
      chk("fl_imm", ex_imm, 32'd9);

      // Flush overrides load-use.
      step(0, 0, LW, 104, 0, 0, 0);
      step(0, 1, ADD, 108, 0, 0, 0);
      chk("fl_lu_ce", 32'(last_ce), 32'd1);
      step(0, 0, NOP, 200, 0, 0, 0);

      // Illegal opcode.
      step(0, 0, 32'hFFFFFFFF, 204, 0, 0, 0);
      chk("ill_valid", 32'(ex_valid), 32'd1);
      chk("ill_ill", 32'(ex_illegal), 32'd1);
      chk("ill_rw", 32'(ex_reg_write), 32'd0);

      // Reset while a load-use stall is pending.
      step(0, 0, LW, 208, 0, 0, 0);
      step(1, 0, ADD, 212, 0, 0, 0);
      chk("rst_st_valid", 32'(ex_valid), 32'd0);
      chk("rst_st_mr", 32'(ex_mem_read), 32'd0);
      step(0, 0, ADD, 212, 0, 0, 0);
      chk("rst_st_ce", 32'(last_ce), 32'd1);

      // Random streams; fetch holds IR/PC when fetch_ce drops.
      cur_ir = NOP; cur_pc = 300;
      for (int n = 0; n < 600; n++) begin
         if (last_ce) begin
            cur_ir = rand_instr();
            cur_pc = cur_pc + 4;
         end
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0), cur_ir, cur_pc,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
